// File: rtl/cpu_capture_pkg.sv
// Shared types and constants for the CPU output capture block.
package cpu_capture_pkg;

    localparam int TOTAL_W = 32;
    localparam int CHK_W   = 16;

    typedef enum logic {
        WD_ACTIVE = 1'b0,
        WD_IDLE   = 1'b1
    } wd_state_t;

endpackage

// File: rtl/capture_fifo.sv
// First-word-fall-through buffer for captured CPU words: storage, pointers and occupancy.
module capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_en,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       push,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop;
    logic              full;

    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = rd_valid && rd_ready;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign push     = wr_en && (!full || pop);
    assign drop     = wr_en && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_output_capture.sv
// Captures CPU output words into a FWFT buffer with drop flag, word total and idle watchdog.
// Define CPU_CAPTURE_CHECKSUM_EN to add a 16-bit running sum of accepted words.
//
// Watchdog states:
//   state     | meaning
//   WD_ACTIVE | counting consecutive cycles without in_en
//   WD_IDLE   | TIMEOUT idle cycles seen; idle asserted until next in_en
module cpu_output_capture
    import cpu_capture_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_en,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    idle,
`ifdef CPU_CAPTURE_CHECKSUM_EN
    output logic [CHK_W-1:0]        checksum,
`endif
    output logic [TOTAL_W-1:0]      total
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic            push;
    logic            drop;
    wd_state_t       wd_state;
    wd_state_t       wd_state_next;
    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_next;

    capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (in_data),
        .wr_en    (in_en),
        .rd_ready (out_ready),
        .rd_data  (out_data),
        .rd_valid (out_valid),
        .count    (count),
        .push     (push),
        .drop     (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            total    <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push) begin
                total <= total + TOTAL_W'(1);
            end
        end
    end

`ifdef CPU_CAPTURE_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum + CHK_W'(in_data);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_state <= WD_ACTIVE;
            wd_cnt   <= '0;
        end else begin
            wd_state <= wd_state_next;
            wd_cnt   <= wd_cnt_next;
        end
    end

    // The counter saturates at TIMEOUT; IDLE is entered on the edge it gets there.
    always_comb begin
        wd_state_next = wd_state;
        wd_cnt_next   = wd_cnt;
        if (in_en) begin
            wd_cnt_next   = '0;
            wd_state_next = WD_ACTIVE;
        end else if (TIMEOUT != 0) begin
            if (wd_cnt != WD_LIMIT) begin
                wd_cnt_next = wd_cnt + WD_W'(1);
            end
            if (wd_cnt_next == WD_LIMIT) begin
                wd_state_next = WD_IDLE;
            end
        end
    end

    assign idle = (wd_state == WD_IDLE);

endmodule

// File: tb/tb_cpu_output_capture.sv
// Self-checking bench for cpu_output_capture: queue-based reference model plus directed literal checks.
module tb_cpu_output_capture;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int TO  = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    count;
    logic          overflow;
    logic          idle;
    logic [31:0]   total;
`ifdef CPU_CAPTURE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    cpu_output_capture #(
        .DATA_W  (DW),
        .DEPTH   (DEP),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_en     (in_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .idle      (idle),
`ifdef CPU_CAPTURE_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .total     (total)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted words plus simple tallies.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int unsigned   m_total;
    int            m_run;
    logic [15:0]   m_chk;
    bit            cmp_on = 1'b0;
    bit            saw_drop = 1'b0;

    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_total = 0;
            m_run   = 0;
            m_chk   = '0;
        end else begin
            do_pop  = (mq.size() > 0) && out_ready;
            do_push = in_en && ((mq.size() < DEP) || do_pop);
            if (in_en && !do_push) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(in_data);
                m_total = m_total + 1;
                m_chk   = m_chk + 16'(in_data);
            end
            if (in_en) m_run = 0;
            else       m_run = m_run + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            chk("out_data",  32'(out_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("count",     32'(count),     32'(mq.size()));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("idle",      32'(idle),      32'(m_run >= TO));
            chk("total",     total,          m_total);
`ifdef CPU_CAPTURE_CHECKSUM_EN
            chk("checksum",  32'(checksum),  32'(m_chk));
`endif
            if (out_valid && out_data == 8'hEE) saw_drop = 1'b1;
        end
    end

    // Called at a negedge; applies inputs, lets one rising edge consume them, returns at next negedge.
    task automatic cyc(input logic en, input logic [DW-1:0] d, input logic rdy);
        in_en     = en;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_en     = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst    = 1'b0;
        cmp_on = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_idle", 32'(idle), 0);
        chk("rst_total", total, 0);
        chk("rst_ovf", 32'(overflow), 0);

        cyc(1, 8'h41, 0);
        cyc(1, 8'h42, 0);
        chk("two_count", 32'(count), 2);
        chk("two_head", 32'(out_data), 32'h41);
        chk("two_total", total, 2);

        for (int i = 0; i < 14; i++) cyc(1, 8'(8'h10 + i), 0);
        chk("full_count", 32'(count), 16);

        cyc(1, 8'h77, 1);
        chk("fullpp_count", 32'(count), 16);
        chk("fullpp_ovf", 32'(overflow), 0);
        chk("fullpp_total", total, 17);
        chk("fullpp_head", 32'(out_data), 32'h42);

        cyc(1, 8'hEE, 0);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_count", 32'(count), 16);
        chk("drop_total", total, 17);

        for (int i = 0; i < 16; i++) cyc(0, 0, 1);
        chk("drain_count", 32'(count), 0);
        chk("drop_unseen", 32'(saw_drop), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);

        cyc(1, 8'h55, 0);
        chk("wd_pulse_idle", 32'(idle), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("wd_early_idle", 32'(idle), 0);
        end
        cyc(0, 0, 0);
        chk("wd_fire_idle", 32'(idle), 1);
        cyc(0, 0, 0);
        chk("wd_hold_idle", 32'(idle), 1);
        cyc(1, 8'h56, 0);
        chk("wd_clear_idle", 32'(idle), 0);

        for (int i = 0; i < 40; i++) cyc((i % 3) != 2, 8'(8'hA0 + i), (i % 2) == 1);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1);
        chk("wrap_drain_count", 32'(count), 0);

        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
        chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_idle", 32'(idle), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_count", 32'(count), 0);
        chk("async_total", total, 0);
        chk("async_idle", 32'(idle), 0);
        chk("async_data", 32'(out_data), 0);
        chk("async_ovf", 32'(overflow), 0);
        cyc(0, 0, 0);
        rst = 1'b0;

        cyc(1, 8'hFF, 0);
        cyc(1, 8'h01, 0);
        cyc(1, 8'h10, 0);
        cyc(0, 0, 0);
        chk("post_rst_total", total, 3);
        chk("post_rst_head", 32'(out_data), 32'hFF);
        chk("post_rst_count", 32'(count), 3);
`ifdef CPU_CAPTURE_CHECKSUM_EN
        chk("checksum_lit", 32'(checksum), 32'h0110);
`endif
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
